alu_op_sequencer: RTL and testbench

- Front-end controller for the 32-bit ALU.
- Accepts one operation request at a time over a valid/ready handshake, latches the opcode and operands, and drives the ALU's one-hot control lines and A/B inputs.
- Holds the controls for a per-operation latency so multi-cycle MUL/DIV paths settle, then captures the 64-bit result (HI/LO) and presents it on a valid/ready response port.
- Sits between the control unit / testbench and the ALU, in place of directly asserting ALU strobes.

---
 rtl/alu_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Purpose : front-end controller for the 32-bit ALU; latches one request,
//           holds one-hot ALU strobes for the op's latency, then returns the
//           64-bit {HI,LO} result on a valid/ready response port.
// Latency : BASIC_LAT / MUL_LAT / DIV_LAT EXEC cycles, plus one cycle to
//           present the response. Illegal op and divide-by-zero answer in one cycle.
// Backpres: a single op is in flight. req_ready is low from acceptance until the
//           response handshake. The response is held stable while rsp_ready is low.
//
// Ports:
//   clock, clear           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready    request handshake; req_op, req_a, req_b are the payload
//   alu_a, alu_b, alu_ctrl operands and one-hot strobes driven to the ALU
//   alu_result             {HI,LO} returned by the ALU
//   rsp_valid/rsp_ready    response handshake; rsp_hi, rsp_lo, rsp_err are the payload
//   busy                   high whenever the sequencer is not idle
module alu_op_sequencer #(
  parameter int BASIC_LAT = 1,
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 8,
  parameter int CNT_W     = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [12:0] alu_ctrl,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] OP_MUL     = 4'd6;
  localparam logic [3:0] OP_DIV     = 4'd7;
  localparam logic [3:0] OP_MAX_LEG = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic [31:0]        a_q, b_q;
  logic [12:0]        ctrl_q;      // one-hot; also serves as the latched opcode
  logic [CNT_W-1:0]   cnt_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [31:0]        rsp_hi_q, rsp_lo_q;
  logic               busy_q;

  // Decode of the incoming request, only meaningful while accepting.
  logic               op_legal_d;
  logic               div_zero_d;
  logic [CNT_W-1:0]   cnt_load_d;
  logic [12:0]        ctrl_load_d;

  always_comb begin
    op_legal_d  = (req_op <= OP_MAX_LEG);
    div_zero_d  = (req_op == OP_DIV) && (req_b == 32'd0);
    ctrl_load_d = 13'd1 << req_op;
    case (req_op)
      OP_MUL:  cnt_load_d = CNT_W'(MUL_LAT - 1);
      OP_DIV:  cnt_load_d = CNT_W'(DIV_LAT - 1);
      default: cnt_load_d = CNT_W'(BASIC_LAT - 1);
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      ctrl_q      <= 13'd0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_hi_q    <= 32'd0;
      rsp_lo_q    <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            a_q         <= req_a;
            b_q         <= req_b;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (!op_legal_d) begin
              // Rejected without ever strobing the ALU.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_hi_q    <= 32'd0;
              rsp_lo_q    <= 32'd0;
            end else if (div_zero_d) begin
              // Remainder = dividend, quotient = all ones, flagged as error.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_hi_q    <= req_a;
              rsp_lo_q    <= 32'hFFFF_FFFF;
            end else begin
              state_q <= EXEC;
              cnt_q   <= cnt_load_d;
              ctrl_q  <= ctrl_load_d;
            end
          end
        end

        EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Strobes have been held for the full latency; result has settled.
            state_q     <= RESP;
            ctrl_q      <= 13'd0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_hi_q    <= alu_result[63:32];
            rsp_lo_q    <= alu_result[31:0];
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          ctrl_q      <= 13'd0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural multi-cycle ALU.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b;
  logic [12:0] alu_ctrl;
  logic [63:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi, rsp_lo;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int held   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_op_sequencer dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU: the result is only correct once the strobe has been held
  // for the op's settle time; before that it shows a poison pattern.
  function automatic logic [63:0] alu_fn(input logic [12:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [63:0] rr;
    logic [31:0] q, r;
    alu_fn = 64'd0;
    case (c)
      13'h0001: alu_fn = {32'd0, a & b};
      13'h0002: alu_fn = {32'd0, a | b};
      13'h0004: alu_fn = {32'd0, ~a};
      13'h0008: alu_fn = {32'd0, -a};
      13'h0010: alu_fn = {32'd0, a + b};
      13'h0020: alu_fn = {32'd0, a - b};
      13'h0040: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        alu_fn = p;
      end
      13'h0080: begin
        if (b != 32'd0) begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          alu_fn = {r, q};
        end
      end
      13'h0100: alu_fn = {32'd0, a >> b[4:0]};
      13'h0200: alu_fn = {32'd0, $signed(a) >>> b[4:0]};
      13'h0400: alu_fn = {32'd0, a << b[4:0]};
      13'h0800: begin rr = {a, a} >> b[4:0]; alu_fn = {32'd0, rr[31:0]}; end
      13'h1000: begin rr = {a, a} << b[4:0]; alu_fn = {32'd0, rr[63:32]}; end
      default:  alu_fn = 64'd0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (alu_ctrl == 13'd0) held <= 0;
    else                   held <= held + 1;
  end

  always_comb begin
    int need;
    need = 1;
    if (alu_ctrl == 13'h0040) need = 4;
    if (alu_ctrl == 13'h0080) need = 8;
    if (alu_ctrl != 13'd0 && held >= need - 1) alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    else                                      alu_result = 64'hBAD0_BAD0_BAD0_BAD0;
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          acc;
    int          dly;
    string       name;
  } exp_t;

  exp_t sbq[$];

  // Monitor: pops one expectation per response handshake.
  bit prev_vld = 1'b0;
  int rise_cyc = 0;
  always @(negedge clock) begin
    exp_t e;
    if (clear) begin
      prev_vld = 1'b0;
    end else begin
      if (rsp_valid && !prev_vld) rise_cyc = cyc;
      prev_vld = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got hi=%h lo=%h err=%b, expected no response", rsp_hi, rsp_lo, rsp_err);
        end else begin
          e = sbq.pop_front();
          if (rsp_hi !== e.hi || rsp_lo !== e.lo || rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp_data[%s]: got hi=%h lo=%h err=%b, expected hi=%h lo=%h err=%b",
                     e.name, rsp_hi, rsp_lo, rsp_err, e.hi, e.lo, e.err);
          end
          checks++;
          if (rise_cyc - e.acc != e.dly) begin
            errors++;
            $display("FAIL rsp_latency[%s]: got %0d cycles, expected %0d", e.name, rise_cyc - e.acc, e.dly);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int w = 0;
    @(negedge clock);
    while (!req_ready && w < 50) begin @(negedge clock); w++; end
    ok = req_ready;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout: got req_ready=0, expected 1", name);
    end
  endtask

  // Issue one request; strobes = expected EXEC cycles (0 for error paths);
  // stall = cycles rsp_ready is held low after the response appears.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic eerr,
                       input int strobes, input int stall);
    exp_t e;
    bit ok, bad;
    int w, nstr;
    logic [12:0] ectrl;
    logic [31:0] got_a, got_b;
    wait_ready(name, ok);
    if (!ok) return;
    rsp_ready = (stall == 0);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    e.hi = ehi; e.lo = elo; e.err = eerr; e.acc = cyc + 1; e.dly = strobes; e.name = name;
    sbq.push_back(e);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 4'(op + 1);
    ectrl = (strobes > 0) ? (13'd1 << op) : 13'd0;
    nstr = 0; bad = 1'b0; w = 0; got_a = 32'd0; got_b = 32'd0;
    while (!rsp_valid && w < 40) begin
      if (ectrl != 13'd0 && alu_ctrl == ectrl) begin
        if (nstr == 0) begin got_a = alu_a; got_b = alu_b; end
        nstr++;
      end else if (alu_ctrl != 13'd0) bad = 1'b1;
      @(negedge clock); w++;
    end
    check({name, "_strobe_cycles"}, 64'(nstr), 64'(strobes));
    check({name, "_strobe_wrong_bit"}, 64'(bad), 64'd0);
    check({name, "_ctrl_in_resp"}, 64'(alu_ctrl), 64'd0);
    if (strobes > 0) check({name, "_alu_ab"}, {got_a, got_b}, {a, b});
    if (stall > 0) begin
      bad = 1'b0;
      for (int i = 0; i < stall; i++) begin
        if (!rsp_valid || rsp_lo !== elo || rsp_hi !== ehi || req_ready) bad = 1'b1;
        req_valid = (i % 2 == 1); req_op = 4'd4; req_a = 32'd100; req_b = 32'd200;
        @(negedge clock);
      end
      req_valid = 1'b0;
      check({name, "_stall_hold"}, 64'(bad), 64'd0);
      @(posedge clock); #1 rsp_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check({name, "_idle_after_ready"}, {61'd0, rsp_valid, req_ready, busy}, {61'd0, 3'b010});
    end
    w = 0;
    while (rsp_valid && w < 40) begin @(negedge clock); w++; end
    check({name, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    bit ok, bad;
    clear = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b1;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    check("reset_ctrl", {rsp_valid, rsp_err, req_ready, busy, 13'(alu_ctrl)}, {4'b0010, 13'd0});
    check("reset_rsp", {rsp_hi, rsp_lo}, 64'd0);
    check("reset_alu_ab", {alu_a, alu_b}, 64'd0);
    clear = 1'b0;

    do_op("add",   4'd4,  32'd5,          32'd7, 32'd0,          32'd12,          1'b0, 1, 0);
    do_op("mul",   4'd6,  32'hFFFF_FFFF,  32'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFE,   1'b0, 4, 0);
    do_op("div",   4'd7,  32'd17,         32'd5, 32'd2,          32'd3,           1'b0, 8, 0);
    do_op("div0",  4'd7,  32'd9,          32'd0, 32'd9,          32'hFFFF_FFFF,   1'b1, 0, 0);
    do_op("ill14", 4'd14, 32'd123,        32'd456, 32'd0,        32'd0,           1'b1, 0, 0);
    do_op("sub",   4'd5,  32'd3,          32'd5, 32'd0,          32'hFFFF_FFFE,   1'b0, 1, 0);
    do_op("ror",   4'd11, 32'd1,          32'd1, 32'd0,          32'h8000_0000,   1'b0, 1, 0);
    do_op("not",   4'd2,  32'h0F0F_0F0F,  32'd0, 32'd0,          32'hF0F0_F0F0,   1'b0, 1, 0);
    do_op("shl",   4'd10, 32'd1,          32'd4, 32'd0,          32'd16,          1'b0, 1, 5);
    do_op("or",    4'd1,  32'h00F0,       32'h0F00, 32'd0,       32'h0FF0,        1'b0, 1, 0);

    // Abort a MUL mid-EXEC with a two-cycle clear; no response may follow.
    wait_ready("abort", ok);
    if (ok) begin
      req_valid = 1'b1; req_op = 4'd6; req_a = 32'd3; req_b = 32'd3;
      @(posedge clock); @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      check("abort_exec_strobe", 64'(alu_ctrl), 64'h40);
      clear = 1'b1;
      @(negedge clock);
      check("abort_after_clear", {rsp_valid, req_ready, busy, 13'(alu_ctrl)}, {3'b010, 13'd0});
      check("abort_rsp_zero", {rsp_hi, rsp_lo, 31'd0, rsp_err}, 96'd0);
      @(negedge clock);
      clear = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (rsp_valid || alu_ctrl != 13'd0) bad = 1'b1;
        @(negedge clock);
      end
      check("abort_no_response", 64'(bad), 64'd0);
    end

    do_op("add2", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1, 0);

    repeat (4) @(negedge clock);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
